// File: rtl/monitor_triangular.sv
// monitor_triangular: locks onto a 0..15..0 triangular counter and reports endpoints, periods and violations.
module monitor_triangular (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] valor,
    input  logic       valido,
    input  logic       limpa,
    output logic       sincronizado,
    output logic       direcao,
    output logic       topo,
    output logic       base,
    output logic       erro,
    output logic [7:0] periodos,
    output logic [7:0] erros
);
    typedef enum logic [2:0] {BUSCA, SOBE, TOPO, DESCE, BASE} estado_t;
    estado_t    estado_q, estado_d;
    logic [3:0] esperado_q, esperado_d, amostra_q, amostra_d;
    logic       tem_amostra_q, tem_amostra_d;
    logic       topo_q, topo_d, base_q, base_d, erro_q, erro_d;
    logic [7:0] periodos_q, periodos_d, erros_q, erros_d;
    logic       viol, conta;
    always_comb begin
        estado_d      = estado_q;
        esperado_d    = esperado_q;
        amostra_d     = amostra_q;
        tem_amostra_d = tem_amostra_q;
        topo_d        = 1'b0;
        base_d        = 1'b0;
        viol          = 1'b0;
        conta         = 1'b0;
        if (valido) begin
            case (estado_q)
                BUSCA: begin
                    if (!tem_amostra_q) begin
                        amostra_d     = valor;
                        tem_amostra_d = 1'b1;
                    end else if (amostra_q != 4'd15 && valor == amostra_q + 4'd1) begin
                        estado_d      = (valor == 4'd15) ? TOPO : SOBE;
                        topo_d        = (valor == 4'd15);
                        esperado_d    = valor + 4'd1;
                        tem_amostra_d = 1'b0;
                    end else if (amostra_q != 4'd0 && valor == amostra_q - 4'd1) begin
                        estado_d      = (valor == 4'd0) ? BASE : DESCE;
                        base_d        = (valor == 4'd0);
                        esperado_d    = valor - 4'd1;
                        tem_amostra_d = 1'b0;
                    end else if (amostra_q == valor && (valor == 4'd15 || valor == 4'd0)) begin
                        // A held endpoint already tells us the direction of travel.
                        estado_d      = (valor == 4'd15) ? DESCE : SOBE;
                        esperado_d    = (valor == 4'd15) ? 4'd14 : 4'd1;
                        tem_amostra_d = 1'b0;
                    end else begin
                        amostra_d = valor;
                    end
                end
                SOBE: begin
                    viol       = (valor != esperado_q);
                    estado_d   = (valor == 4'd15) ? TOPO : SOBE;
                    topo_d     = (valor == 4'd15);
                    esperado_d = valor + 4'd1;
                end
                TOPO: begin
                    viol       = (valor != 4'd15);
                    estado_d   = DESCE;
                    esperado_d = 4'd14;
                end
                DESCE: begin
                    viol       = (valor != esperado_q);
                    estado_d   = (valor == 4'd0) ? BASE : DESCE;
                    base_d     = (valor == 4'd0);
                    esperado_d = valor - 4'd1;
                end
                BASE: begin
                    viol       = (valor != 4'd0);
                    conta      = 1'b1;
                    estado_d   = SOBE;
                    esperado_d = 4'd1;
                end
                default: estado_d = BUSCA;
            endcase
            if (viol) begin
                estado_d      = BUSCA;
                esperado_d    = esperado_q;
                amostra_d     = valor;
                tem_amostra_d = 1'b1;
                topo_d        = 1'b0;
                base_d        = 1'b0;
                conta         = 1'b0;
            end
        end
        erro_d     = viol;
        periodos_d = limpa ? 8'd0 : periodos_q + {7'd0, conta};
        erros_d    = limpa ? 8'd0 : erros_q + {7'd0, viol && erros_q != 8'hFF};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= BUSCA;
            esperado_q    <= 4'd0;
            amostra_q     <= 4'd0;
            tem_amostra_q <= 1'b0;
            topo_q        <= 1'b0;
            base_q        <= 1'b0;
            erro_q        <= 1'b0;
            periodos_q    <= 8'd0;
            erros_q       <= 8'd0;
        end else begin
            estado_q      <= estado_d;
            esperado_q    <= esperado_d;
            amostra_q     <= amostra_d;
            tem_amostra_q <= tem_amostra_d;
            topo_q        <= topo_d;
            base_q        <= base_d;
            erro_q        <= erro_d;
            periodos_q    <= periodos_d;
            erros_q       <= erros_d;
        end
    end
    assign sincronizado = (estado_q != BUSCA);
    assign direcao      = (estado_q == DESCE) || (estado_q == BASE);
    assign topo         = topo_q;
    assign base         = base_q;
    assign erro         = erro_q;
    assign periodos     = periodos_q;
    assign erros        = erros_q;
endmodule

// File: tb/tb_monitor_triangular.sv
// tb_monitor_triangular: vector table, directed corner sequences and random stimulus against a phase-based model.
module tb_monitor_triangular;
    logic       clock = 1'b0, reset = 1'b1, valido = 1'b0, limpa = 1'b0;
    logic [3:0] valor = 4'd0;
    logic       sincronizado, direcao, topo, base, erro;
    logic [7:0] periodos, erros;
    int tests = 0, fails = 0;

    monitor_triangular dut (
        .clock(clock), .reset(reset), .valor(valor), .valido(valido), .limpa(limpa),
        .sincronizado(sincronizado), .direcao(direcao), .topo(topo), .base(base),
        .erro(erro), .periodos(periodos), .erros(erros)
    );

    always #5 clock = ~clock;

    // Model: when locked, m_q is the index (0..31) of the last accepted sample in the period.
    bit m_lock, m_have, m_t, m_b, m_e;
    int m_q, m_a, m_per, m_err;

    function automatic int f(input int p);
        return (p < 16) ? p : 31 - p;
    endfunction

    task automatic model_reset();
        m_lock = 0; m_have = 0; m_t = 0; m_b = 0; m_e = 0;
        m_q = 0; m_a = 0; m_per = 0; m_err = 0;
    endtask

    task automatic model_step(input bit vd, input int v, input bit lm);
        bit viol = 0, inc = 0, found = 0;
        m_t = 0; m_b = 0; m_e = 0;
        if (vd) begin
            if (m_lock) begin
                if (v == f((m_q + 1) % 32)) begin
                    m_q = (m_q + 1) % 32;
                    m_t = (m_q == 15); m_b = (m_q == 31); inc = (m_q == 0);
                end else begin
                    viol = 1; m_e = 1; m_lock = 0; m_have = 1; m_a = v;
                end
            end else if (!m_have) begin
                m_have = 1; m_a = v;
            end else begin
                for (int p = 0; p < 32; p++)
                    if (!found && f(p) == m_a && f((p + 1) % 32) == v) begin
                        found = 1; m_lock = 1; m_q = (p + 1) % 32;
                        m_t = (m_q == 15); m_b = (m_q == 31);
                    end
                if (!found) m_a = v;
            end
        end
        if (lm) begin
            m_per = 0; m_err = 0;
        end else begin
            m_per = (m_per + int'(inc)) % 256;
            if (viol && m_err < 255) m_err++;
        end
    endtask

    function automatic logic [20:0] model_out();
        bit d = m_lock && m_q >= 16;
        return {m_lock, d, m_t, m_b, m_e, 8'(m_per), 8'(m_err)};
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [20:0] dut_out();
        return {sincronizado, direcao, topo, base, erro, periodos, erros};
    endfunction

    task automatic step(input bit vd, input int v, input bit lm);
        valido = vd; valor = 4'(v); limpa = lm;
        @(posedge clock); #1;
        model_step(vd, v, lm);
        check("model", dut_out(), model_out());
    endtask

    task automatic do_reset();
        reset = 1'b1; #1;
        model_reset();
        check("reset_async", dut_out(), 21'd0);
        @(posedge clock); #1;
        check("reset_held", dut_out(), 21'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        bit vd; int v; bit lm;
        bit s, d, t, b, e; int ers;
    } vec_t;
    vec_t tbl[19];

    initial begin
        int nbase;
        tbl = '{
            '{1, 0, 0, 0,0,0,0,0, 0}, '{1, 1, 0, 1,0,0,0,0, 0}, '{1, 2, 0, 1,0,0,0,0, 0},
            '{1, 3, 0, 1,0,0,0,0, 0}, '{0,10, 0, 1,0,0,0,0, 0}, '{1, 4, 0, 1,0,0,0,0, 0},
            '{1, 5, 0, 1,0,0,0,0, 0}, '{1, 6, 0, 1,0,0,0,0, 0}, '{1, 9, 0, 0,0,0,0,1, 1},
            '{1,10, 0, 1,0,0,0,0, 1}, '{1,11, 0, 1,0,0,0,0, 1}, '{0,15, 0, 1,0,0,0,0, 1},
            '{1,12, 0, 1,0,0,0,0, 1}, '{1,13, 0, 1,0,0,0,0, 1}, '{1,14, 0, 1,0,0,0,0, 1},
            '{1,15, 0, 1,0,1,0,0, 1}, '{1,15, 0, 1,1,0,0,0, 1}, '{1,14, 0, 1,1,0,0,0, 1},
            '{1,14, 1, 0,0,0,0,1, 0}
        };
        do_reset();
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].vd, tbl[i].v, tbl[i].lm);
            check($sformatf("vec%0d", i), {sincronizado, direcao, topo, base, erro, erros},
                  {tbl[i].s, tbl[i].d, tbl[i].t, tbl[i].b, tbl[i].e, 8'(tbl[i].ers)});
        end

        // Two full periods starting from 0,1.
        do_reset();
        nbase = 0;
        for (int k = 0; k < 66; k++) begin
            step(1, f(k % 32), 0);
            nbase += int'(base);
        end
        check("two_periods", {periods_pad(periodos), erros, 8'(nbase)}, {8'd2, 8'd0, 8'd2});

        // Saturate erros via alternating violation and relock.
        for (int k = 0; k < 260; k++) begin
            step(1, 9, 0);
            step(1, 10, 0);
        end
        check("erros_sat", {4'd0, erros}, {4'd0, 8'd255});
        step(1, 3, 1);
        check("limpa_viol", {erro, erros}, {1'b1, 8'd0});

        // Reset in mid-period, then relock from scratch.
        step(1, 4, 0); step(1, 5, 0); step(1, 6, 0);
        do_reset();
        step(1, 7, 0);
        check("post_reset_first", {4'd0, sincronizado, erro}, 6'd0);
        step(1, 8, 0);

        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(199) == 0) do_reset();
            else begin
                bit vd = ($urandom_range(9) != 0);
                bit lm = ($urandom_range(59) == 0);
                int v = $urandom_range(15);
                if (m_lock && $urandom_range(19) != 0) v = f((m_q + 1) % 32);
                else if (!m_lock && m_have && $urandom_range(1) == 0) v = (m_a + 1) % 16;
                step(vd, v, lm);
            end
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic [7:0] periods_pad(input logic [7:0] x);
        return x;
    endfunction
endmodule
